// File: rtl/demux_scheduler_if.sv
// Source-side and channel-side signals of demux_scheduler, bundled for port use.
// slave: the scheduler itself; master: whatever drives the source and sinks.
interface demux_scheduler_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] X;
  logic             x_valid;
  logic             x_ready;
  logic [3:0]       out_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [1:0]       Sel;
  logic             Enable;
  logic [7:0]       count;

  modport slave (
    input  X, x_valid, out_ready,
    output x_ready, out_valid, A, B, C, D, Sel, Enable, count
  );

  modport master (
    output X, x_valid, out_ready,
    input  x_ready, out_valid, A, B, C, D, Sel, Enable, count
  );
endinterface

// File: rtl/demux_scheduler.sv
// One-word-at-a-time demux that rotates captured words across channels A..D.
// Define DEMUX_SKIP_BUSY_EN to target the first ready channel from the rotation pointer.
module demux_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  demux_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, DELIVER} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       count_q, count_d;
  logic [1:0]       target;

`ifdef DEMUX_SKIP_BUSY_EN
  // Scan upward from the pointer with wrap; fall back to the pointer when no sink is ready.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    target = rr_q;
    found  = 1'b0;
    cand   = rr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!found && bus.out_ready[cand]) begin
        target = cand;
        found  = 1'b1;
      end
    end
  end
`else
  assign target = rr_q;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.x_valid) begin
          data_d  = bus.X;
          sel_d   = target;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (bus.out_ready[sel_q]) begin
          count_d = count_q + 8'd1;
          rr_d    = sel_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 2'b00;
      sel_q   <= 2'b00;
      data_q  <= '0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Reset also gates x_ready so nothing looks acceptable while the block is held.
  always_comb begin
    bus.x_ready   = (state_q == IDLE) && !reset;
    bus.Enable    = (state_q == DELIVER);
    bus.out_valid = 4'b0000;
    bus.A         = '0;
    bus.B         = '0;
    bus.C         = '0;
    bus.D         = '0;
    bus.Sel       = sel_q;
    bus.count     = count_q;
    if (state_q == DELIVER) begin
      bus.out_valid[sel_q] = 1'b1;
      unique case (sel_q)
        2'd0:    bus.A = data_q;
        2'd1:    bus.B = data_q;
        2'd2:    bus.C = data_q;
        default: bus.D = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: rotation, hold under backpressure, async reset,
// count wrap and, when DEMUX_SKIP_BUSY_EN is defined, busy-channel skipping.
module tb_demux_scheduler;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  int   exp_rr;
  int   exp_count;

  demux_scheduler_if #(.WIDTH(4)) bus ();

  demux_scheduler #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present x for one edge, then check the freshly loaded delivery state.
  task automatic applyStimulus(input logic [3:0] x, input int exp_sel, input string tag);
    logic [15:0] lanes;
    @(negedge clk);
    checkOutput({tag, " x_ready idle"}, 32'(bus.x_ready), 32'd1);
    bus.X       = x;
    bus.x_valid = 1'b1;
    tick();
    bus.x_valid = 1'b0;
    lanes = 16'(x) << (4 * exp_sel);
    checkOutput({tag, " Sel"},       32'(bus.Sel), 32'(exp_sel));
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'(4'b0001 << exp_sel));
    checkOutput({tag, " lanes"},     32'({bus.D, bus.C, bus.B, bus.A}), 32'(lanes));
    checkOutput({tag, " Enable"},    32'(bus.Enable), 32'd1);
    checkOutput({tag, " x_ready"},   32'(bus.x_ready), 32'd0);
  endtask

  // Ready sink everywhere: capture, then the following edge completes.
  task automatic sendAndComplete(input logic [3:0] x, input string tag);
    applyStimulus(x, exp_rr, tag);
    tick();
    exp_rr    = (exp_rr + 1) % 4;
    exp_count = (exp_count + 1) % 256;
    checkOutput({tag, " valid pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_rr    = 0;
    exp_count = 0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    exp_rr      = 0;
    exp_count   = 0;
    reset       = 1'b1;
    bus.X       = 4'h0;
    bus.x_valid = 1'b0;
    bus.out_ready = 4'b0000;

    #12;
    checkOutput("rst x_ready",   32'(bus.x_ready), 32'd0);
    checkOutput("rst Enable",    32'(bus.Enable), 32'd0);
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst lanes",     32'({bus.D, bus.C, bus.B, bus.A}), 32'd0);
    checkOutput("rst Sel",       32'(bus.Sel), 32'd0);
    checkOutput("rst count",     32'(bus.count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("idle x_ready", 32'(bus.x_ready), 32'd1);

    // Five words A,B,C,D,A
    bus.out_ready = 4'b1111;
    for (int i = 1; i <= 5; i++) sendAndComplete(4'(i), $sformatf("rot%0d", i));
    checkOutput("rot count", 32'(bus.count), 32'd5);

    // Backpressure on B for six sampled cycles, X churns meanwhile
    bus.out_ready = 4'b1101;
    applyStimulus(4'd9, 1, "hold");
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.X       = 4'(k + 2);
      bus.x_valid = 1'b1;
      tick();
      checkOutput($sformatf("hold%0d B", k),     32'(bus.B), 32'd9);
      checkOutput($sformatf("hold%0d valid", k), 32'(bus.out_valid), 32'b0010);
      checkOutput($sformatf("hold%0d En", k),    32'(bus.Enable), 32'd1);
      checkOutput($sformatf("hold%0d rdy", k),   32'(bus.x_ready), 32'd0);
    end
    @(negedge clk);
    bus.x_valid   = 1'b0;
    bus.out_ready = 4'b1111;
    tick();
    exp_rr = 2;
    checkOutput("hold done En",    32'(bus.Enable), 32'd0);
    checkOutput("hold done count", 32'(bus.count), 32'd6);

    // Reset mid-delivery on C
    bus.out_ready = 4'b0000;
    applyStimulus(4'd7, 2, "midrst");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst lanes",   32'({bus.D, bus.C, bus.B, bus.A}), 32'd0);
    checkOutput("midrst valid",   32'(bus.out_valid), 32'd0);
    checkOutput("midrst En",      32'(bus.Enable), 32'd0);
    checkOutput("midrst x_ready", 32'(bus.x_ready), 32'd0);
    checkOutput("midrst count",   32'(bus.count), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    exp_rr    = 0;
    exp_count = 0;
    bus.out_ready = 4'b1111;
    sendAndComplete(4'd6, "postrst");
    checkOutput("postrst count", 32'(bus.count), 32'd1);

    // 255 more words bring count to 256 -> 0; rotation keeps going
    for (int i = 0; i < 255; i++) sendAndComplete(4'(i), "wrap");
    checkOutput("wrap count", 32'(bus.count), 32'd0);
    checkOutput("wrap count model", 32'(bus.count), 32'(exp_count));
    sendAndComplete(4'hA, "afterwrap");
    checkOutput("afterwrap count", 32'(bus.count), 32'd1);

    // Target selection with only C ready, pointer at A
    pulseReset();
    bus.out_ready = 4'b0100;
`ifdef DEMUX_SKIP_BUSY_EN
    applyStimulus(4'd3, 2, "skipC");
    tick();
    checkOutput("skipC done", 32'(bus.Enable), 32'd0);
`else
    applyStimulus(4'd3, 0, "skipC");
    tick();
    checkOutput("skipC wait En",  32'(bus.Enable), 32'd1);
    checkOutput("skipC wait Sel", 32'(bus.Sel), 32'd0);
    @(negedge clk);
    bus.out_ready = 4'b0001;
    tick();
    checkOutput("skipC done", 32'(bus.Enable), 32'd0);
`endif

    // No sink ready: pointer channel regardless of build
    pulseReset();
    bus.out_ready = 4'b0000;
    applyStimulus(4'd5, 0, "none");
    tick();
    checkOutput("none wait En", 32'(bus.Enable), 32'd1);
    @(negedge clk);
    bus.out_ready = 4'b0001;
    tick();
    checkOutput("none done En",    32'(bus.Enable), 32'd0);
    checkOutput("none done count", 32'(bus.count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
